// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the branch predictor slice.
//   - 2-bit saturating counter encodings plus the reset and allocate values.
//   - bp_entry_t: one predictor table entry (valid, tag, target, ctr).
//   - pc_tag(): extracts the tag portion of a PC, right-aligned.
// The entry fields are sized by BP_XLEN. The top-level XLEN parameter must
// match BP_XLEN, because one struct type is shared by every instance.
package bp_pkg;

  localparam int BP_XLEN       = 32;
  localparam int BP_INDEX_BITS = 6;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] CTR_RESET = CTR_WNT;
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // The tag is kept right-aligned at full width. Its upper bits are always
  // zero, so synthesis removes those flops.
  typedef struct packed {
    logic               valid;
    logic [BP_XLEN-1:0] tag;
    logic [BP_XLEN-1:0] target;
    logic [1:0]         ctr;
  } bp_entry_t;

  function automatic logic [BP_XLEN-1:0] pc_tag(input logic [BP_XLEN-1:0] pc,
                                                input int index_bits);
    return pc >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: combinational next state of a 2-bit saturating counter.
// Ports:
//   ctr       in   2  current counter value
//   taken     in   1  branch outcome; 1 counts up, 0 counts down
//   ctr_next  out  2  updated value, clamped to CTR_SNT..CTR_ST
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped, tagged predictor with 2-bit counters.
//   - The fetch side predicts direction and target for fetch_pc
//     combinationally.
//   - The execute side trains the table from each resolved conditional
//     branch.
//   - It reports mispredictions one cycle late and keeps free-running
//     statistics counters.
// Ports:
//   clock, reset_n                rising-edge clock, async active-low reset
//   fetch_pc                      PC fetched this cycle
//   pred_taken, pred_target       combinational prediction for fetch_pc
//   resolve_valid, resolve_pc,    resolving branch: valid, PC, outcome,
//   resolve_taken, resolve_target,  actual target, and the prediction the
//   resolve_pred_taken              branch was fetched with
//   mispredict                    registered: last cycle's resolve mispredicted
//   stat_branches                 resolves since reset (wraps)
//   stat_mispredicts              mispredicts since reset (wraps)
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS,
  parameter int XLEN       = BP_XLEN
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            resolve_valid,
  input  logic [XLEN-1:0] resolve_pc,
  input  logic            resolve_taken,
  input  logic [XLEN-1:0] resolve_target,
  input  logic            resolve_pred_taken,
  output logic            mispredict,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int DEPTH = 2 ** INDEX_BITS;

  // The table is built from flops rather than RAM, so that the async reset
  // can clear every valid bit at once.
  bp_entry_t table_q [DEPTH];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [INDEX_BITS-1:0] resolve_idx;
  logic [XLEN-1:0]       fetch_tag;
  logic [XLEN-1:0]       resolve_tag;
  logic                  fetch_hit;
  logic                  resolve_hit;
  logic                  mispredict_next;
  logic [1:0]            ctr_next;

  assign fetch_idx   = fetch_pc[INDEX_BITS+1:2];
  assign resolve_idx = resolve_pc[INDEX_BITS+1:2];
  assign fetch_tag   = pc_tag(fetch_pc, INDEX_BITS);
  assign resolve_tag = pc_tag(resolve_pc, INDEX_BITS);

  // The prediction reads the registered table, so a same-cycle update to
  // the same index becomes visible only from the next cycle.
  assign fetch_hit   = table_q[fetch_idx].valid && (table_q[fetch_idx].tag == fetch_tag);
  assign pred_taken  = fetch_hit && table_q[fetch_idx].ctr[1];
  assign pred_target = pred_taken ? table_q[fetch_idx].target : fetch_pc + XLEN'(4);

  assign resolve_hit = table_q[resolve_idx].valid &&
                       (table_q[resolve_idx].tag == resolve_tag);

  assign mispredict_next = resolve_valid && (resolve_pred_taken != resolve_taken);

  sat_counter2 u_sat_counter2 (
    .ctr      (table_q[resolve_idx].ctr),
    .taken    (resolve_taken),
    .ctr_next (ctr_next)
  );

  // Training: a hit adjusts the counter, and a taken hit also refreshes the
  // target. A taken miss allocates the entry, evicting any alias. A
  // not-taken miss leaves the table unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
      end
    end else if (resolve_valid) begin
      if (resolve_hit) begin
        table_q[resolve_idx].ctr <= ctr_next;
        if (resolve_taken) table_q[resolve_idx].target <= resolve_target;
      end else if (resolve_taken) begin
        table_q[resolve_idx] <= '{valid: 1'b1, tag: resolve_tag,
                                  target: resolve_target, ctr: CTR_ALLOC};
      end
    end
  end

  // The statistics counters wrap modulo 2**32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mispredict       <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      mispredict       <= mispredict_next;
      stat_branches    <= stat_branches + 32'(resolve_valid);
      stat_mispredicts <= stat_mispredicts + 32'(mispredict_next);
    end
  end

endmodule
